// File: rtl/sdram_arb.sv
// Three-port SDRAM request arbiter: port 0 fixed high priority, ports 1/2 round-robin.
// Optional starvation promotion of ports 1/2 when SDRAM_ARB_STARVE_EN is defined.
module sdram_arb #(
  parameter int AW           = 24,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [3*AW-1:0] m_addr,
  input  logic [3*DW-1:0] m_wdata,
  input  logic [3*4-1:0]  m_wen,
  input  logic [2:0]      m_valid,
  output logic [2:0]      m_ready,
  output logic [DW-1:0]   m_rdata,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [3:0]      mem_wen,
  output logic            mem_valid,
  input  logic            mem_ready,
  input  logic [DW-1:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t     state;
  logic [1:0] g;
  logic [1:0] rr;
  logic [1:0] win;

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("sdram_arb: STARVE_LIMIT must be at least 1");
  end

  function automatic logic [1:0] rr_pick(input logic [1:0] lo_valid, input logic [1:0] ptr);
    if (lo_valid == 2'b11) return ptr;
    else if (lo_valid[0])  return 2'd1;
    else                   return 2'd2;
  endfunction

`ifdef SDRAM_ARB_STARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve1;
  logic [CW-1:0] starve2;
  logic          sat1;
  logic          sat2;

  assign sat1 = m_valid[1] && (starve1 == CW'(STARVE_LIMIT));
  assign sat2 = m_valid[2] && (starve2 == CW'(STARVE_LIMIT));

  always_comb begin
    win = rr_pick(m_valid[2:1], rr);
    if (sat1 && sat2)    win = rr;
    else if (sat1)       win = 2'd1;
    else if (sat2)       win = 2'd2;
    else if (m_valid[0]) win = 2'd0;
  end

  // A port stops aging while it owns the controller and restarts from zero when granted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve1 <= '0;
      starve2 <= '0;
    end else begin
      if (state == IDLE && |m_valid && win == 2'd1)
        starve1 <= '0;
      else if (m_valid[1] && !(state != IDLE && g == 2'd1) && starve1 != CW'(STARVE_LIMIT))
        starve1 <= starve1 + CW'(1);
      if (state == IDLE && |m_valid && win == 2'd2)
        starve2 <= '0;
      else if (m_valid[2] && !(state != IDLE && g == 2'd2) && starve2 != CW'(STARVE_LIMIT))
        starve2 <= starve2 + CW'(1);
    end
  end
`else
  always_comb begin
    win = rr_pick(m_valid[2:1], rr);
    if (m_valid[0]) win = 2'd0;
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      g         <= 2'd0;
      rr        <= 2'd1;
      m_ready   <= 3'b000;
      m_rdata   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wen   <= 4'b0000;
      mem_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|m_valid) begin
            mem_addr  <= m_addr[win*AW +: AW];
            mem_wdata <= m_wdata[win*DW +: DW];
            mem_wen   <= m_wen[win*4 +: 4];
            mem_valid <= 1'b1;
            g         <= win;
            if (win == 2'd1)      rr <= 2'd2;
            else if (win == 2'd2) rr <= 2'd1;
            state     <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (mem_ready) begin
            m_rdata   <= mem_rdata;
            m_ready   <= 3'b001 << g;
            mem_valid <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          // One dead cycle so a master that has not yet seen m_ready is not re-granted.
          m_ready <= 3'b000;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arb.sv
// Self-checking bench for sdram_arb: directed scenarios plus randomized traffic
// checked against a grant-order reference model.
module tb_sdram_arb;
  localparam int AW = 24;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rstn;
  logic [3*AW-1:0] m_addr    = '0;
  logic [3*DW-1:0] m_wdata   = '0;
  logic [3*4-1:0]  m_wen     = '0;
  logic [2:0]      m_valid   = '0;
  logic [2:0]      m_ready;
  logic [DW-1:0]   m_rdata;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [3:0]      mem_wen;
  logic            mem_valid;
  logic            mem_ready = 1'b0;
  logic [DW-1:0]   mem_rdata = '0;

  sdram_arb #(.AW(AW), .DW(DW), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rstn(rstn),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wen(m_wen), .m_valid(m_valid),
    .m_ready(m_ready), .m_rdata(m_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int rr_m   = 1;
  logic [DW-1:0] last_rd = '0;
  logic [AW-1:0] ra [3];
  logic [DW-1:0] rw [3];
  logic [3:0]    re [3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [AW-1:0] a, input logic [DW-1:0] w,
                         input logic [3:0] e);
    ra[p] = a; rw[p] = w; re[p] = e;
    m_addr[p*AW +: AW]  = a;
    m_wdata[p*DW +: DW] = w;
    m_wen[p*4 +: 4]     = e;
    m_valid[p]          = 1'b1;
  endtask

  task automatic rand_req(input int p);
    set_req(p, AW'($urandom), $urandom, 4'($urandom));
  endtask

  // Reference rule: port 0 first; otherwise the preferred low port, else the other one.
  function automatic int pick(input logic [2:0] v, input int pref);
    if (v[0])        return 0;
    if (v[pref])     return pref;
    if (v[3 - pref]) return 3 - pref;
    return -1;
  endfunction

  task automatic do_txn(input int delay, input logic [DW-1:0] rd, output int port);
    int exp;
    exp  = pick(m_valid, rr_m);
    port = exp;
    tick;
    chk("grant_valid", 64'(mem_valid), 64'(1));
    chk("grant_addr",  64'(mem_addr),  64'(ra[exp]));
    chk("grant_wdata", 64'(mem_wdata), 64'(rw[exp]));
    chk("grant_wen",   64'(mem_wen),   64'(re[exp]));
    for (int i = 0; i < delay; i++) begin
      tick;
      chk("hold_valid", 64'(mem_valid), 64'(1));
      chk("hold_addr",  64'(mem_addr),  64'(ra[exp]));
      chk("hold_wdata", 64'(mem_wdata), 64'(rw[exp]));
      chk("hold_wen",   64'(mem_wen),   64'(re[exp]));
      chk("hold_ready", 64'(m_ready),   64'(0));
    end
    mem_ready = 1'b1;
    mem_rdata = rd;
    tick;
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    chk("done_ready",     64'(m_ready),   64'(1) << exp);
    chk("done_rdata",     64'(m_rdata),   64'(rd));
    chk("done_mem_valid", 64'(mem_valid), 64'(0));
    last_rd = rd;
    if (exp == 1)      rr_m = 2;
    else if (exp == 2) rr_m = 1;
  endtask

  task automatic finish_txn;
    tick;
    chk("idle_ready",      64'(m_ready), 64'(0));
    chk("idle_rdata_hold", 64'(m_rdata), 64'(last_rd));
  endtask

  task automatic do_reset;
    m_valid   = 3'b000;
    mem_ready = 1'b0;
    #2 rstn = 1'b0;
    #10 rstn = 1'b1;
    rr_m    = 1;
    last_rd = '0;
    tick;
  endtask

  initial begin
    int p;
    logic seen1;

    // Reset values
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #20;
    chk("rst_m_ready",   64'(m_ready),   64'(0));
    chk("rst_m_rdata",   64'(m_rdata),   64'(0));
    chk("rst_mem_valid", 64'(mem_valid), 64'(0));
    chk("rst_mem_addr",  64'(mem_addr),  64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_mem_wen",   64'(mem_wen),   64'(0));
    rstn = 1'b1;
    tick;

    // Single port 1 read
    set_req(1, 24'h000123, 32'h0, 4'b0000);
    do_txn(2, 32'hDEADBEEF, p);
    m_valid = 3'b000;
    finish_txn;
    chk("p1_idle_no_grant", 64'(mem_valid), 64'(0));
    mem_ready = 1'b1;
    mem_rdata = 32'h12345678;
    tick;
    mem_ready = 1'b0;
    chk("stray_ready_m_ready", 64'(m_ready),   64'(0));
    chk("stray_ready_rdata",   64'(m_rdata),   64'(last_rd));
    chk("stray_ready_valid",   64'(mem_valid), 64'(0));

    // All three ports requesting, immediate replies
    do_reset;
    set_req(0, 24'h000A00, 32'hA0, 4'b0000);
    set_req(1, 24'h000B00, 32'hB0, 4'b1111);
    set_req(2, 24'h000C00, 32'hC0, 4'b0001);
    for (int k = 0; k < 3; k++) begin
      do_txn(0, $urandom, p);
      if (k < 2) set_req(p, ra[p] + 24'd1, rw[p], re[p]);
      else       m_valid[0] = 1'b0;
      finish_txn;
    end
    for (int k = 0; k < 4; k++) begin
      do_txn(0, $urandom, p);
      set_req(p, ra[p] + 24'd1, rw[p], re[p]);
      finish_txn;
    end

    // Port 2 write held across 5 ACTIVE cycles
    do_reset;
    set_req(2, 24'h00F00D, 32'h0000ABCD, 4'b0011);
    do_txn(5, 32'h0, p);
    m_valid = 3'b000;
    finish_txn;

    // Reset pulsed during ACTIVE, then during DONE
    do_reset;
    set_req(1, 24'h000111, 32'h11, 4'b0000);
    set_req(2, 24'h000222, 32'h22, 4'b0000);
    tick;
    tick;
    #2 rstn = 1'b0;
    #1;
    chk("arst_active_mem_valid", 64'(mem_valid), 64'(0));
    chk("arst_active_m_ready",   64'(m_ready),   64'(0));
    chk("arst_active_mem_addr",  64'(mem_addr),  64'(0));
    #3 rstn = 1'b1;
    rr_m = 1; last_rd = '0;
    do_txn(0, 32'hCAFE0001, p);
    #2 rstn = 1'b0;
    #1;
    chk("arst_done_m_ready",   64'(m_ready), 64'(0));
    chk("arst_done_m_rdata",   64'(m_rdata), 64'(0));
    #3 rstn = 1'b1;
    rr_m = 1; last_rd = '0;
    set_req(0, 24'h000333, 32'h33, 4'b0100);
    do_txn(1, 32'hCAFE0002, p);
    m_valid = 3'b000;
    finish_txn;

    // Ports 0 and 1 both requesting continuously
    do_reset;
    set_req(0, 24'h000A0A, 32'h0A, 4'b0000);
    set_req(1, 24'h000B0B, 32'h0B, 4'b0000);
`ifdef SDRAM_ARB_STARVE_EN
    seen1 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick;
      if (mem_valid === 1'b1 && mem_addr === ra[1]) seen1 = 1'b1;
      mem_ready = 1'b1;
      tick;
      mem_ready = 1'b0;
      tick;
    end
    chk("starve_p1_granted", 64'(seen1), 64'(1));
    m_valid = 3'b000;
    tick;
`else
    seen1 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      do_txn(0, $urandom, p);
      if (p == 1) seen1 = 1'b1;
      set_req(0, ra[0], rw[0], re[0]);
      finish_txn;
    end
    chk("no_starve_p1_blocked", 64'(seen1 || m_ready[1]), 64'(0));
    m_valid = 3'b000;
    tick;

    // Randomized traffic against the reference model
    do_reset;
    rand_req($urandom_range(0, 2));
    for (int k = 0; k < 40; k++) begin
      if (m_valid == 3'b000) rand_req($urandom_range(0, 2));
      do_txn($urandom_range(0, 3), $urandom, p);
      if ($urandom_range(0, 1) == 1) rand_req(p);
      else m_valid[p] = 1'b0;
      for (int q = 0; q < 3; q++)
        if (!m_valid[q] && $urandom_range(0, 2) == 0) rand_req(q);
      finish_txn;
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sdram_arb.md
# sdram_arb

Three-port request arbiter that shares the single SoC SDRAM controller port among the video fetch engine, the CPU memory bus and the USB/DMA engine. It sits in `soc` between those masters and the SDRAM controller that drives the `sdram_*` pins. Port 0 (video) has fixed high priority. Ports 1 and 2 alternate round-robin. One transaction is in flight at a time.

## Interface
Parameters:
- `AW`, 24, word address width.
- `DW`, 32, data width.
- `STARVE_LIMIT`, 64, wait cycles before a low-priority port is promoted (only with `SDRAM_ARB_STARVE_EN`).

Ports:
- `clk`  in  1  system clock (clk48m domain); the only clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `m_addr`  in  3*AW  per-port word address; port p is bits [p*AW +: AW].
- `m_wdata`  in  3*DW  per-port write data.
- `m_wen`  in  3*4  per-port byte write enables; all zero means read.
- `m_valid`  in  3  per-port request, held high until that port's `m_ready`.
- `m_ready`  out  3  one-cycle completion pulse per port.
- `m_rdata`  out  DW  read data, shared by all ports, valid while `m_ready` is nonzero.
- `mem_addr`  out  AW  to the SDRAM controller.
- `mem_wdata`  out  DW  to the SDRAM controller.
- `mem_wen`  out  4  to the SDRAM controller.
- `mem_valid`  out  1  request to the controller.
- `mem_ready`  in  1  controller completion pulse.
- `mem_rdata`  in  DW  controller read data, valid with `mem_ready`.

## Operation
State machine: IDLE → ACTIVE → DONE → IDLE.

- IDLE: if any `m_valid` bit is set, pick a winner, latch its addr/wdata/wen into `mem_*`, set `mem_valid`=1, record grant index `g`, and go to ACTIVE. If no bit is set, stay in IDLE.
- Winner selection:
  - Port 0 wins if valid.
  - Otherwise, if only one of ports 1/2 is valid, that port wins.
  - Otherwise, if both are valid, the port pointed to by `rr` wins.
  - After a grant to port 1 or 2, `rr` points at the other one. A grant to port 0 leaves `rr` unchanged.
- ACTIVE: `mem_*` outputs stay stable. When `mem_ready`=1:
  - capture `mem_rdata` into `m_rdata`;
  - set `m_ready[g]`=1;
  - clear `mem_valid` on that same edge;
  - go to DONE.
- DONE: `m_ready[g]` is high for exactly this cycle. The master drops `m_valid` or presents its next request. Then go to IDLE. This state prevents a stale `m_valid` from being re-granted.
- Widths:
  - `m_rdata` holds its last value outside DONE.
  - `rr` resets to port 1.
- Master drops `m_valid` during ACTIVE: this is a protocol violation. The transaction still completes and `m_ready[g]` still pulses.
- `mem_ready` asserted in IDLE or DONE: ignored.

## Timing
- Reset values: all `m_ready`=0, `m_rdata`=0, `mem_valid`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wen`=0, state IDLE, `rr`=1, starvation counters 0.
- Asserting `rstn` low mid-transaction forces the reset values immediately. The controller must treat the `mem_valid` fall as an abort.
- Latency:
  - `m_valid` is sampled high in IDLE at edge N.
  - `mem_valid` is high after edge N.
  - If `mem_ready` is sampled at edge M, `m_ready[g]` and `m_rdata` are valid in cycle M..M+1.
  - The next grant can occur at edge M+2.
  - Minimum cost is 3 cycles per transaction when the controller answers on the first cycle.
- Simultaneous requests on all three ports: port 0 wins. Ports 1/2 are served afterwards in `rr` order.

## Configuration
Macro: `SDRAM_ARB_STARVE_EN`.

Defined:
- Ports 1 and 2 each have a saturating counter. It increments each cycle the port's `m_valid` is high and the port is not the current grant, and clears when that port is granted.
- In IDLE, a counter at `STARVE_LIMIT` beats port 0.
- If both counters are saturated, `rr` decides between ports 1 and 2.

Undefined:
- No counters are built.
- Port 0 always wins.

## Test plan
- Single port 1 read:
  - stimulus: `m_valid`=3'b010, addr 0x000123; controller returns 0xDEADBEEF 2 cycles after `mem_valid`.
  - required: `mem_addr`=0x000123 with `mem_wen`=0; `m_ready`=3'b010 for one cycle with `m_rdata`=0xDEADBEEF; state is IDLE 1 cycle later.
- All three ports valid continuously, controller replies immediately:
  - required: grant order 0,0,0… while port 0 is held.
  - then, with port 0 dropped: order 1,2,1,2.
- Port 2 write, wen 4'b0011, wdata 0x0000ABCD:
  - required: `mem_wen`=4'b0011 and `mem_wdata`=0x0000ABCD are stable across 5 ACTIVE cycles; `mem_valid` falls on the `mem_ready` edge.
- `rstn` pulsed low during ACTIVE:
  - required: `mem_valid`=0 and `m_ready`=0 asynchronously; the first grant after release goes to port 0 if it is valid, otherwise to port 1 when ports 1 and 2 are both valid.
- With `SDRAM_ARB_STARVE_EN`, `STARVE_LIMIT`=8, ports 0 and 1 requesting continuously:
  - required: port 1 is granted within 8 waiting cycles despite port 0.
  - without the macro: port 1 is never granted.
